// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst master.
// Accepts one command at a time (read or write, 1..2^BLW-1 beats) and runs it
// as a single wb_cyc transaction with cti-tagged incrementing addresses.
// Optional build macro WB_BURST_MASTER_TMO_EN adds a stall watchdog that
// aborts a burst after TMO_LIMIT stalled cycles and pulses err_tmo.
module wb_burst_master #(
  parameter int APP_AW    = 26,
  parameter int DW        = 32,
  parameter int BLW       = 4,
  parameter int TMO_LIMIT = 255
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  // command
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [BLW-1:0]    cmd_len,
  input  logic [DW/8-1:0]   cmd_sel,
  // write data
  input  logic [DW-1:0]     wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  // read data
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  // status
  output logic              busy,
  output logic              done,
  output logic              err_tmo,
  // wishbone
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [APP_AW-1:0] wb_addr,
  output logic [DW/8-1:0]   wb_sel,
  output logic [DW-1:0]     wb_dati,
  input  logic [DW-1:0]     wb_dato,
  input  logic              wb_ack,
  output logic [2:0]        wb_cti
);

  localparam logic [APP_AW-1:0] ADDR_STEP = APP_AW'(DW / 8);

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t         state;
  logic [BLW-1:0] remaining;
  logic [BLW-1:0] len_eff;
  logic           beat_done;
  logic           last_beat;
  logic           tmo_hit;

  // A zero-length command is treated as a single beat.
  assign len_eff   = (cmd_len == '0) ? BLW'(1) : cmd_len;

  assign cmd_ready = (state == IDLE) & ~wb_rst;
  assign busy      = (state == XFER);

  // Writes only strobe while the source has a beat ready, so a data gap
  // stalls the bus instead of sending stale data.
  assign wb_stb    = wb_cyc & (~wb_we | wr_valid);
  assign wb_dati   = wr_data;

  // An ack only counts while our own strobe is up.
  assign beat_done = wb_cyc & wb_stb & wb_ack;
  assign wr_ready  = wb_cyc & wb_stb & wb_we & wb_ack;
  assign last_beat = (remaining == BLW'(1));

`ifdef WB_BURST_MASTER_TMO_EN
  localparam int TMO_W = (TMO_LIMIT > 1) ? $clog2(TMO_LIMIT + 1) : 1;

  logic [TMO_W-1:0] stall_cnt;

  // Abort on the edge where the stall count would reach TMO_LIMIT.
  assign tmo_hit = wb_stb & ~wb_ack & (stall_cnt == TMO_W'(TMO_LIMIT - 1));

  // Stall watchdog: counts strobed cycles without ack, cleared on ack or idle.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      stall_cnt <= '0;
      err_tmo   <= 1'b0;
    end else begin
      err_tmo <= tmo_hit;
      if ((state != XFER) || wb_ack) begin
        stall_cnt <= '0;
      end else if (wb_stb) begin
        stall_cnt <= stall_cnt + TMO_W'(1);
      end
    end
  end
`else
  // Without the watchdog the master waits for an ack indefinitely.
  assign tmo_hit = 1'b0;
  assign err_tmo = 1'b0;
`endif

  // Burst sequencer: command capture, beat accounting, bus and read-data regs.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state     <= IDLE;
      wb_cyc    <= 1'b0;
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_sel    <= '0;
      wb_cti    <= CTI_CLASSIC;
      remaining <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge register values and the default pulses below are simply
      // overridden by later assignments in the same edge.
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state     <= XFER;
            wb_cyc    <= 1'b1;
            wb_we     <= cmd_we;
            wb_addr   <= cmd_addr;
            wb_sel    <= cmd_sel;
            remaining <= len_eff;
            wb_cti    <= (len_eff == BLW'(1)) ? CTI_CLASSIC : CTI_INCR;
          end
        end
        XFER: begin
          if (beat_done) begin
            wb_addr   <= wb_addr + ADDR_STEP;
            remaining <= remaining - BLW'(1);
            if (!wb_we) begin
              rd_valid <= 1'b1;
              rd_data  <= wb_dato;
              rd_last  <= last_beat;
            end
            if (last_beat) begin
              state  <= IDLE;
              wb_cyc <= 1'b0;
              wb_we  <= 1'b0;
              wb_cti <= CTI_CLASSIC;
              done   <= 1'b1;
            end else if (remaining == BLW'(2)) begin
              wb_cti <= CTI_END;
            end
          end else if (tmo_hit) begin
            state  <= IDLE;
            wb_cyc <= 1'b0;
            wb_we  <= 1'b0;
            wb_cti <= CTI_CLASSIC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: scoreboarded beats and read data,
// a wait-state Wishbone slave, and a write-data source with gap control.
`timescale 1ns/1ps
module tb_wb_burst_master;

  localparam int APP_AW    = 26;
  localparam int DW        = 32;
  localparam int BLW       = 4;
  localparam int TMO_LIMIT = 255;
  localparam int SW        = DW / 8;

  logic              wb_clk;
  logic              wb_rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [APP_AW-1:0] cmd_addr;
  logic [BLW-1:0]    cmd_len;
  logic [SW-1:0]     cmd_sel;
  logic [DW-1:0]     wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              busy;
  logic              done;
  logic              err_tmo;
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [APP_AW-1:0] wb_addr;
  logic [SW-1:0]     wb_sel;
  logic [DW-1:0]     wb_dati;
  logic [DW-1:0]     wb_dato;
  logic              wb_ack;
  logic [2:0]        wb_cti;

  wb_burst_master #(
    .APP_AW(APP_AW), .DW(DW), .BLW(BLW), .TMO_LIMIT(TMO_LIMIT)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .busy(busy), .done(done), .err_tmo(err_tmo),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_sel(wb_sel), .wb_dati(wb_dati), .wb_dato(wb_dato), .wb_ack(wb_ack),
    .wb_cti(wb_cti)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  always @(posedge wb_clk) cycle <= cycle + 1;

  typedef struct {
    logic [APP_AW-1:0] addr;
    logic [2:0]        cti;
    logic              we;
    logic [SW-1:0]     sel;
    logic [DW-1:0]     data;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } rd_t;

  beat_t         beat_q[$];
  rd_t           rd_q[$];
  logic [DW-1:0] wr_src_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave read data is a fixed function of the address it is presented.
  function automatic logic [DW-1:0] rd_pat(input logic [APP_AW-1:0] a);
    return {6'h2B, a} ^ 32'h0000_5A5A;
  endfunction

  assign wb_dato = rd_pat(wb_addr);

  // Wishbone slave: acks after slave_wait stalled strobe cycles, or never.
  int   slave_wait = 0;
  logic slave_hold = 1'b0;
  initial begin : slave
    int waited;
    waited = 0;
    wb_ack = 1'b0;
    forever begin
      @(posedge wb_clk);
      #2;
      if (wb_cyc && wb_stb && !slave_hold) begin
        if (waited >= slave_wait) begin
          wb_ack = 1'b1;
          waited = 0;
        end else begin
          wb_ack = 1'b0;
          waited++;
        end
      end else begin
        wb_ack = 1'b0;
      end
    end
  end

  // Write-data source: presents the head of wr_src_q unless a gap is forced.
  logic wr_gap = 1'b0;
  initial begin : wsrc
    wr_valid = 1'b0;
    wr_data  = '0;
    forever begin
      @(posedge wb_clk);
      #1;
      wr_valid = (wr_src_q.size() != 0) && !wr_gap;
      wr_data  = (wr_src_q.size() != 0) ? wr_src_q[0] : '0;
    end
  end

  // Monitor: compares every completed beat and read return with the scoreboard.
  int done_cnt = 0;
  int rd_cnt = 0;
  int wr_ready_cnt = 0;
  int last_beat_cycle = -10;
  int last_done_cycle = -10;
  always @(negedge wb_clk) begin : mon
    beat_t e;
    rd_t   r;
    if (wb_cyc && wb_stb && wb_ack) begin
      check("beat_expected", beat_q.size() != 0, 1);
      if (beat_q.size() != 0) begin
        e = beat_q.pop_front();
        check("beat_addr", wb_addr, e.addr);
        check("beat_cti", wb_cti, e.cti);
        check("beat_we", wb_we, e.we);
        check("beat_sel", wb_sel, e.sel);
        if (e.we) begin
          check("beat_wdata", wb_dati, e.data);
          check("beat_wr_ready", wr_ready, 1);
        end else begin
          check("beat_rd_no_wr_ready", wr_ready, 0);
        end
      end
      last_beat_cycle = cycle;
    end
    if (wr_ready) begin
      wr_ready_cnt++;
      if (wr_src_q.size() != 0) wr_src_q.delete(0);
    end
    if (rd_valid) begin
      rd_cnt++;
      check("rd_expected", rd_q.size() != 0, 1);
      if (rd_q.size() != 0) begin
        r = rd_q.pop_front();
        check("rd_data", rd_data, r.data);
        check("rd_last", rd_last, r.last);
      end
    end
    if (done) begin
      done_cnt++;
      last_done_cycle = cycle;
      check("done_after_last_beat", cycle, last_beat_cycle + 1);
      check("cyc_low_on_done", wb_cyc, 0);
    end
  end

  // Pushes the expected beats, then drives the command until accepted.
  // Returns just after the accepting edge with cmd_valid still high.
  int accept_cycle = 0;
  task automatic send_cmd(input logic we, input logic [APP_AW-1:0] addr,
                          input logic [BLW-1:0] len, input logic [SW-1:0] sel,
                          input logic expect_beats);
    int   n;
    logic accepted;
    n = (len == '0) ? 1 : int'(len);
    if (expect_beats) begin
      for (int i = 0; i < n; i++) begin
        beat_t b;
        rd_t   r;
        b.addr = addr + APP_AW'(i * SW);
        b.cti  = (n == 1) ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
        b.we   = we;
        b.sel  = sel;
        b.data = '0;
        if (we) begin
          b.data = $urandom();
          wr_src_q.push_back(b.data);
        end else begin
          r.data = rd_pat(b.addr);
          r.last = (i == n - 1);
          rd_q.push_back(r);
        end
        beat_q.push_back(b);
      end
    end
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    accepted  = 1'b0;
    for (int k = 0; k < 200 && !accepted; k++) begin
      @(negedge wb_clk);
      if (cmd_ready) begin
        accepted     = 1'b1;
        accept_cycle = cycle;
      end
    end
    check("cmd_accepted", accepted, 1);
    @(posedge wb_clk);
    #1;
    check("busy_after_accept", busy, 1);
    check("cyc_after_accept", wb_cyc, 1);
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge wb_clk);
      if (done) seen = 1'b1;
    end
    check(tag, seen, 1);
    @(negedge wb_clk);
    check({tag, "_pulse_width"}, done, 0);
    @(posedge wb_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_cmd_ready"}, cmd_ready, 0);
    check({p, "_cyc"}, wb_cyc, 0);
    check({p, "_stb"}, wb_stb, 0);
    check({p, "_we"}, wb_we, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
    check({p, "_err_tmo"}, err_tmo, 0);
    check({p, "_rd_valid"}, rd_valid, 0);
    check({p, "_rd_last"}, rd_last, 0);
    check({p, "_rd_data"}, rd_data, 0);
    check({p, "_addr"}, wb_addr, 0);
    check({p, "_sel"}, wb_sel, 0);
    check({p, "_cti"}, wb_cti, 0);
  endtask

  initial begin : main
    int   base;
    int   beats;
    logic flag_a;
    logic flag_b;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_sel   = '0;
    wb_rst    = 1'b1;

    // Reset state, cmd_ready held low while reset is high.
    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk);
    check_reset_outputs("por");
    @(posedge wb_clk);
    #1;
    wb_rst = 1'b0;
    @(negedge wb_clk);
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    @(posedge wb_clk);
    #1;

    // Single read, two wait states.
    slave_wait = 2;
    base = rd_cnt;
    send_cmd(1'b0, 26'h100, 4'd1, 4'hF, 1'b1);
    cmd_valid = 1'b0;
    wait_done("single_read_done");
    check("single_read_rd_count", rd_cnt - base, 1);

    // Zero length is one beat.
    slave_wait = 0;
    base = rd_cnt;
    send_cmd(1'b0, 26'h040, 4'd0, 4'h3, 1'b1);
    cmd_valid = 1'b0;
    wait_done("len0_done");
    check("len0_rd_count", rd_cnt - base, 1);

    // Write burst with a two-cycle data gap after beat 2.
    base  = wr_ready_cnt;
    beats = 0;
    send_cmd(1'b1, 26'h200, 4'd4, 4'hF, 1'b1);
    cmd_valid = 1'b0;
    for (int k = 0; k < 50 && beats < 2; k++) begin
      @(negedge wb_clk);
      if (wr_ready) beats++;
    end
    check("wr_two_beats_before_gap", beats, 2);
    wr_gap = 1'b1;
    @(negedge wb_clk);
    check("wr_gap1_stb", wb_stb, 0);
    check("wr_gap1_cyc", wb_cyc, 1);
    @(negedge wb_clk);
    check("wr_gap2_stb", wb_stb, 0);
    check("wr_gap2_cyc", wb_cyc, 1);
    wr_gap = 1'b0;
    wait_done("write_done");
    check("wr_ready_pulses", wr_ready_cnt - base, 4);

    // Address wrap at the top of the byte address space.
    send_cmd(1'b0, 26'h3FF_FFFC, 4'd2, 4'hF, 1'b1);
    cmd_valid = 1'b0;
    wait_done("wrap_done");

    // Slave that never acks.
    base = done_cnt;
    slave_hold = 1'b1;
`ifdef WB_BURST_MASTER_TMO_EN
    send_cmd(1'b0, 26'h300, 4'd1, 4'hF, 1'b0);
    cmd_valid = 1'b0;
    flag_a = 1'b0;
    for (int k = 0; k < 400 && !flag_a; k++) begin
      @(negedge wb_clk);
      if (err_tmo) flag_a = 1'b1;
    end
    check("tmo_err_seen", flag_a, 1);
    check("tmo_stall_cycles", cycle - (accept_cycle + 1), TMO_LIMIT);
    check("tmo_cyc_low", wb_cyc, 0);
    check("tmo_cmd_ready", cmd_ready, 1);
    @(negedge wb_clk);
    check("tmo_err_pulse_width", err_tmo, 0);
    check("tmo_no_done", done_cnt - base, 0);
    @(posedge wb_clk);
    #1;
    slave_hold = 1'b0;
    send_cmd(1'b0, 26'h310, 4'd1, 4'hF, 1'b1);
    cmd_valid = 1'b0;
    wait_done("after_tmo_done");
`else
    send_cmd(1'b0, 26'h300, 4'd1, 4'hF, 1'b1);
    cmd_valid = 1'b0;
    flag_a = 1'b0;
    flag_b = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge wb_clk);
      if (err_tmo) flag_a = 1'b1;
      if (!wb_cyc) flag_b = 1'b1;
    end
    check("stall_no_err", flag_a, 0);
    check("stall_cyc_held", flag_b, 0);
    check("stall_no_done", done_cnt - base, 0);
    slave_hold = 1'b0;
    wait_done("stall_release_done");
`endif

    // Reset on beat 2 of an 8-beat read.
    base  = done_cnt;
    beats = 0;
    send_cmd(1'b0, 26'h500, 4'd8, 4'hF, 1'b1);
    cmd_valid = 1'b0;
    for (int k = 0; k < 50 && beats < 2; k++) begin
      @(negedge wb_clk);
      if (wb_cyc && wb_stb && wb_ack) beats++;
    end
    check("rst_mid_reached_beat2", beats, 2);
    wb_rst = 1'b1;
    @(negedge wb_clk);
    check_reset_outputs("rst_mid");
    @(posedge wb_clk);
    #1;
    wb_rst = 1'b0;
    beat_q.delete();
    rd_q.delete();
    @(negedge wb_clk);
    check("rst_mid_no_done", done_cnt - base, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    @(posedge wb_clk);
    #1;

    // Back-to-back len-3 reads with cmd_valid held high.
    send_cmd(1'b0, 26'h600, 4'd3, 4'hF, 1'b1);
    send_cmd(1'b0, 26'h700, 4'd3, 4'hF, 1'b1);
    check("b2b_accept_on_done", accept_cycle, last_done_cycle);
    cmd_valid = 1'b0;
    wait_done("b2b_second_done");

    check("beat_q_drained", beat_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    check("wr_src_drained", wr_src_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 The block SHALL have parameter APP_AW, default 26, meaning Wishbone byte-address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width (multiple of 8).
REQ-003 The block SHALL have parameter BLW, default 4, meaning burst-length field width (max burst 2^BLW-1 beats).
REQ-004 The block SHALL have parameter TMO_LIMIT, default 255, meaning stalled cycles without ack before abort.
REQ-005 The block SHALL have these clock and reset ports: wb_clk in 1, the single clock; wb_rst in 1, synchronous active-high reset.
REQ-006 The block SHALL have these command ports: cmd_valid in 1, command request; cmd_ready out 1, command accepted when high with cmd_valid; cmd_we in 1, 1 write / 0 read; cmd_addr in APP_AW, start byte address; cmd_len in BLW, beat count; cmd_sel in DW/8, byte enables.
REQ-007 The block SHALL have these write-data ports: wr_data in DW, write beat data; wr_valid in 1, write data available; wr_ready out 1, beat consumed.
REQ-008 The block SHALL have these read-data ports: rd_data out DW, read beat; rd_valid out 1, rd_data valid; rd_last out 1, final beat of burst.
REQ-009 The block SHALL have these status ports: busy out 1, burst in progress; done out 1, one-cycle completion pulse; err_tmo out 1, one-cycle timeout-abort pulse.
REQ-010 The block SHALL have these Wishbone ports: wb_cyc out 1; wb_stb out 1; wb_we out 1; wb_addr out APP_AW; wb_sel out DW/8; wb_dati out DW, master-to-slave data; wb_dato in DW, slave-to-master data; wb_ack in 1; wb_cti out 3.

Function
REQ-011 The FSM SHALL have states IDLE and XFER; cmd_ready = (state==IDLE) & ~wb_rst.
REQ-012 The FSM SHALL go from IDLE to XFER on the edge where cmd_valid & cmd_ready; it SHALL latch we/addr/sel and remaining = (cmd_len==0 ? 1 : cmd_len); wb_cyc SHALL go high the following cycle.
REQ-013 In XFER, wb_cyc SHALL be 1; wb_stb SHALL be 1 for reads and SHALL equal wr_valid for writes.
REQ-014 For writes, wb_dati SHALL be wr_data combinationally; wr_ready = wb_cyc & wb_stb & wb_we & wb_ack.
REQ-015 A beat SHALL complete on a cycle with wb_cyc & wb_stb & wb_ack; wb_ack in any other cycle SHALL be ignored.
REQ-016 On each completed beat, wb_addr SHALL advance by DW/8 modulo 2^APP_AW, and remaining SHALL decrement.
REQ-017 wb_cti SHALL be 3'b000 for a 1-beat burst, 3'b010 for non-final beats, and 3'b111 on the final beat.
REQ-018 For reads, rd_data/rd_valid SHALL be registered: one cycle after each completed read beat, rd_valid=1 with the sampled wb_dato; rd_last=1 with the final beat only.
REQ-019 When the final beat completes, the FSM SHALL return to IDLE; wb_cyc/wb_stb SHALL drop the next cycle, with done=1 for exactly that cycle.
REQ-020 A command with cmd_valid high on the cycle done is high SHALL be accepted, giving back-to-back bursts with one idle cycle of wb_cyc.
REQ-021 busy SHALL equal (state==XFER).

Reset
REQ-022 The synchronous wb_rst SHALL force: state IDLE; wb_cyc, wb_stb, wb_we, rd_valid, rd_last, done, err_tmo, and busy to 0; wb_addr, wb_sel, wb_cti, rd_data, and counters to 0.
REQ-023 Reset asserted mid-burst SHALL drop wb_cyc at the next edge with no done or err_tmo pulse; cmd_ready SHALL stay low while wb_rst is high.

Configuration
REQ-024 Macro WB_BURST_MASTER_TMO_EN, when defined, SHALL enable a stall counter: it increments each cycle with wb_stb & ~wb_ack and clears on ack or in IDLE.
REQ-025 With WB_BURST_MASTER_TMO_EN defined, when the counter reaches TMO_LIMIT the block SHALL abort: return to IDLE, drop wb_cyc next cycle, and pulse err_tmo for one cycle with no done pulse.
REQ-026 Without WB_BURST_MASTER_TMO_EN, no counter SHALL exist, err_tmo SHALL be tied 0, and the block SHALL wait for wb_ack indefinitely.

Verification
REQ-027 The bench SHALL cover this single read: addr 0x100, len 1, ack after 2 wait cycles -> cti 000; rd_valid once with rd_last=1; done one cycle after ack.
REQ-028 The bench SHALL cover this write burst: len 4, addr 0x200, wr_valid low for 2 cycles mid-burst -> stb drops during the gap; addr sequence 0x200/204/208/20C; cti 010,010,010,111; 4 wr_ready pulses.
REQ-029 The bench SHALL cover address wrap: APP_AW=26, addr 0x3FFFFFC, read len 2 -> second beat addr 0x0000000.
REQ-030 The bench SHALL cover timeout: TMO_EN defined, TMO_LIMIT=255, slave never acks -> err_tmo pulse at stall count 255; cyc low; done never asserted; next command accepted.
REQ-031 The bench SHALL cover reset mid-burst: reset asserted on beat 2 of len 8 -> cyc low next edge; all outputs at reset values; no done.
REQ-032 The bench SHALL cover back-to-back: two len-3 reads with cmd_valid held high -> second accepted on the done cycle; exactly one cycle with cyc low between bursts.
